regfile_sb: RTL and testbench

//  Parametrised multi-read-port integer register file with per-register scoreboard (busy bits).

---
 rtl/regfile_sb.sv | 105 ++++++++++
 tb/tb_regfile_sb.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port integer register file with per-register busy scoreboard.
// Decode reads operands/busy flags and claims destinations on issue; EXU writeback
// writes data and releases the claim. x0 reads as zero and is never busy.
// Optional build macro: REGFILE_BYPASS_EN (write-through bypass of wb data to read ports).
module regfile_sb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRP  = 2,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRP*AW-1:0]   rs_addr,
    output logic [NRP*XLEN-1:0] rs_data,
    output logic [NRP-1:0]      rs_busy,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic [AW:0]         pend_cnt
);

    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic            wb_en;
    logic            issue_acc;
    logic [AW-1:0]   addr;

    assign wb_en       = wb_valid && (wb_rd != '0);
    // WAW stall looks at registered busy only; a same-cycle wb does not release it
    assign issue_ready = !issue_valid || (issue_rd == '0) || !busy[issue_rd];
    assign issue_acc   = issue_valid && issue_ready && (issue_rd != '0);

    // Next busy vector: wb clears, then issue sets (so issue+wb to same rd ends busy); flush wins
    always_comb begin
        busy_nxt = busy;
        if (wb_en) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (flush) begin
            busy_nxt = '0;
        end else if (issue_acc) begin
            busy_nxt[issue_rd] = 1'b1;
        end
    end

    // Population count of the next busy vector, registered alongside it
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
        end
    end

    // Scoreboard and outstanding-write counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    // Register storage; writes to x0 are dropped, flush keeps data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Combinational read ports with optional same-cycle writeback bypass
    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        addr    = '0;
        for (int p = 0; p < int'(NRP); p++) begin
            addr = rs_addr[p*AW +: AW];
            if (addr != '0) begin
                rs_data[p*XLEN +: XLEN] = regs[addr];
                rs_busy[p]              = busy[addr];
            end
`ifdef REGFILE_BYPASS_EN
            if (wb_en && (wb_rd == addr)) begin
                rs_data[p*XLEN +: XLEN] = wb_data;
                rs_busy[p]              = 1'b0;
            end
`else
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed-vector bench for regfile_sb (XLEN=32, NREG=32, NRP=2).
module tb_regfile_sb;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRP  = 2;
    localparam int unsigned AW   = 5;

    logic                clk;
    logic                rst_n;
    logic [NRP*AW-1:0]   rs_addr;
    logic [NRP*XLEN-1:0] rs_data;
    logic [NRP-1:0]      rs_busy;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                issue_ready;
    logic                wb_valid;
    logic [AW-1:0]       wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic                flush;
    logic [AW:0]         pend_cnt;

    int tests_run;
    int tests_failed;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs_addr     (rs_addr),
        .rs_data     (rs_data),
        .rs_busy     (rs_busy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flush       (flush),
        .pend_cnt    (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edge, then drop single-cycle strobes and let outputs settle
    task automatic tick();
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        flush       = 1'b0;
        #1;
    endtask

    task automatic set_rs(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rs_addr = {a1, a0};
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_rs(5'd2, 5'd5);
        #2;
        tests_run++;
        if (rs_data !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_rs_data: got %h expected %h", rs_data, 64'h0);
        end
        tests_run++;
        if (rs_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_rs_busy: got %b expected %b", rs_busy, 2'b00);
        end
        tests_run++;
        if (pend_cnt !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_pend_cnt: got %0d expected 0", pend_cnt);
        end
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        #1;
        tests_run++;
        if (issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_issue_ready: got %b expected 1", issue_ready);
        end
        issue_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_issue_wb();
        issue_valid = 1'b1;
        issue_rd    = 5'd2;
        #1;
        tests_run++;
        if (issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL issue2_ready: got %b expected 1", issue_ready);
        end
        tick();
        set_rs(5'd2, 5'd0);
        tests_run++;
        if (rs_busy !== 2'b01) begin
            tests_failed++;
            $display("FAIL issue2_busy: got %b expected %b", rs_busy, 2'b01);
        end
        tests_run++;
        if (pend_cnt !== 6'd1) begin
            tests_failed++;
            $display("FAIL issue2_pend: got %0d expected 1", pend_cnt);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd2;
        wb_data  = 32'hf0f0feec;
        tick();
        tests_run++;
        if (rs_data[31:0] !== 32'hf0f0feec) begin
            tests_failed++;
            $display("FAIL wb2_data: got %h expected %h", rs_data[31:0], 32'hf0f0feec);
        end
        tests_run++;
        if (rs_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL wb2_busy: got %b expected %b", rs_busy, 2'b00);
        end
        tests_run++;
        if (pend_cnt !== 6'd0) begin
            tests_failed++;
            $display("FAIL wb2_pend: got %0d expected 0", pend_cnt);
        end
    endtask

    task automatic test_waw();
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        tick();
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        #1;
        tests_run++;
        if (issue_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL waw_ready: got %b expected 0", issue_ready);
        end
        tick();
        set_rs(5'd3, 5'd0);
        tests_run++;
        if (rs_busy !== 2'b01) begin
            tests_failed++;
            $display("FAIL waw_busy: got %b expected %b", rs_busy, 2'b01);
        end
        tests_run++;
        if (pend_cnt !== 6'd1) begin
            tests_failed++;
            $display("FAIL waw_pend: got %0d expected 1", pend_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_d;
        logic        exp_b;
`ifdef REGFILE_BYPASS_EN
        exp_d = 32'h0ecccccc;
        exp_b = 1'b0;
`else
        exp_d = 32'h0;
        exp_b = 1'b1;
`endif
        set_rs(5'd3, 5'd0);
        wb_valid    = 1'b1;
        wb_rd       = 5'd3;
        wb_data     = 32'h0ecccccc;
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        #1;
        tests_run++;
        if (rs_data[31:0] !== exp_d) begin
            tests_failed++;
            $display("FAIL bypass_data: got %h expected %h", rs_data[31:0], exp_d);
        end
        tests_run++;
        if (rs_busy[0] !== exp_b) begin
            tests_failed++;
            $display("FAIL bypass_busy: got %b expected %b", rs_busy[0], exp_b);
        end
        tests_run++;
        if (issue_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL waw_wb_same_cycle_ready: got %b expected 0", issue_ready);
        end
        tick();
        tests_run++;
        if (rs_data[31:0] !== 32'h0ecccccc || rs_busy[0] !== 1'b0 || pend_cnt !== 6'd0) begin
            tests_failed++;
            $display("FAIL after_wb3: got data %h busy %b pend %0d expected %h 0 0",
                     rs_data[31:0], rs_busy[0], pend_cnt, 32'h0ecccccc);
        end
    endtask

    task automatic test_x0();
        wb_valid    = 1'b1;
        wb_rd       = 5'd0;
        wb_data     = 32'hfff00000;
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        #1;
        tests_run++;
        if (issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL x0_ready: got %b expected 1", issue_ready);
        end
        tick();
        set_rs(5'd0, 5'd0);
        tests_run++;
        if (rs_data !== 64'h0 || rs_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL x0_read: got data %h busy %b expected 0 00", rs_data, rs_busy);
        end
        tests_run++;
        if (pend_cnt !== 6'd0) begin
            tests_failed++;
            $display("FAIL x0_pend: got %0d expected 0", pend_cnt);
        end
        // Writeback to a register that was never claimed still lands
        wb_valid = 1'b1;
        wb_rd    = 5'd12;
        wb_data  = 32'hcafef00d;
        tick();
        set_rs(5'd0, 5'd12);
        tests_run++;
        if (rs_data[63:32] !== 32'hcafef00d || pend_cnt !== 6'd0) begin
            tests_failed++;
            $display("FAIL wb_nonbusy: got %h pend %0d expected %h 0",
                     rs_data[63:32], pend_cnt, 32'hcafef00d);
        end
    endtask

    task automatic test_same_cycle_issue_wb();
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        wb_valid    = 1'b1;
        wb_rd       = 5'd4;
        wb_data     = 32'h12345678;
        tick();
        set_rs(5'd4, 5'd4);
        tests_run++;
        if (rs_data !== {32'h12345678, 32'h12345678} || rs_busy !== 2'b11) begin
            tests_failed++;
            $display("FAIL issue_wb_same: got data %h busy %b expected %h 11",
                     rs_data, rs_busy, {32'h12345678, 32'h12345678});
        end
        tests_run++;
        if (pend_cnt !== 6'd1) begin
            tests_failed++;
            $display("FAIL issue_wb_same_pend: got %0d expected 1", pend_cnt);
        end
    endtask

    task automatic test_flush();
        logic [AW-1:0] rds [3];
        rds = '{5'd1, 5'd2, 5'd5};
        foreach (rds[i]) begin
            issue_valid = 1'b1;
            issue_rd    = rds[i];
            tick();
        end
        tests_run++;
        if (pend_cnt !== 6'd4) begin
            tests_failed++;
            $display("FAIL pre_flush_pend: got %0d expected 4", pend_cnt);
        end
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        wb_valid    = 1'b1;
        wb_rd       = 5'd1;
        wb_data     = 32'haaaa5555;
        tick();
        tests_run++;
        if (pend_cnt !== 6'd0) begin
            tests_failed++;
            $display("FAIL flush_pend: got %0d expected 0", pend_cnt);
        end
        set_rs(5'd7, 5'd5);
        tests_run++;
        if (rs_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush_busy_7_5: got %b expected 00", rs_busy);
        end
        set_rs(5'd1, 5'd4);
        tests_run++;
        if (rs_data !== {32'h12345678, 32'haaaa5555} || rs_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush_data_kept: got %h busy %b expected %h 00",
                     rs_data, rs_busy, {32'h12345678, 32'haaaa5555});
        end
    endtask

    task automatic test_reset_mid();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        issue_valid = 1'b1;
        issue_rd    = 5'd10;
        tick();
        tests_run++;
        if (pend_cnt !== 6'd2) begin
            tests_failed++;
            $display("FAIL pre_reset_pend: got %0d expected 2", pend_cnt);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd11;
        wb_data  = 32'h55aa55aa;
        @(negedge clk);
        rst_n = 1'b0;
        set_rs(5'd4, 5'd10);
        tests_run++;
        if (pend_cnt !== 6'd0 || rs_data !== 64'h0 || rs_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_reset: got pend %0d data %h busy %b expected 0 0 00",
                     pend_cnt, rs_data, rs_busy);
        end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        set_rs(5'd11, 5'd9);
        tests_run++;
        if (rs_data !== 64'h0 || rs_busy !== 2'b00 || pend_cnt !== 6'd0) begin
            tests_failed++;
            $display("FAIL post_reset_no_wb: got data %h busy %b pend %0d expected 0 00 0",
                     rs_data, rs_busy, pend_cnt);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rs_addr      = '0;
        issue_valid  = 1'b0;
        issue_rd     = '0;
        wb_valid     = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        flush        = 1'b0;
        rst_n        = 1'b0;
        test_reset();
        test_issue_wb();
        test_waw();
        test_bypass();
        test_x0();
        test_same_cycle_issue_wb();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
